mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS datapath. It implements MULT and DIV and owns the HI and LO registers. It sits beside the ALU: it takes operands from the A and B register outputs and is started by the control unit, which stalls in a wait state until Done. Hi/Lo feed the Mem2Reg write-back mux for MFHI/MFLO.

## Interface
- WIDTH, 32, operand width; Hi/Lo are WIDTH each.
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request; sampled only in IDLE.
- Op  in  1  0 = MULT, 1 = DIV.
- A  in  WIDTH  rs operand (multiplicand / dividend), signed.
- B  in  WIDTH  rt operand (multiplier / divisor), signed.
- Hi  out  WIDTH  MULT: product[63:32]; DIV: remainder.
- Lo  out  WIDTH  MULT: product[31:0]; DIV: quotient.
- Busy  out  1  high while an operation is in flight.
- Done  out  1  one-cycle pulse; Hi/Lo already hold the new result in that cycle.
- DivZero  out  1  one-cycle pulse with Done when DIV had B == 0.

## Operation
- States: IDLE, MUL_RUN, DIV_RUN, FINISH.
- IDLE + Start, Op = 0:
  - Capture A and B.
  - Clear the 64-bit accumulator and the Booth extra bit.
  - Count = 0; go to MUL_RUN.
- IDLE + Start, Op = 1, B ≠ 0:
  - Capture |A| and |B|, plus the quotient and remainder sign flags.
  - Count = 0; go to DIV_RUN.
- IDLE + Start, Op = 1, B == 0: go directly to FINISH with the zero-divide flag set.
- MUL_RUN: one radix-2 Booth step per cycle (add, subtract or none, then arithmetic shift right).
- DIV_RUN: one restoring step per cycle on the magnitudes (shift, trial subtract, restore when negative).
- Run states: Count increments each cycle. The transition to FINISH happens on the step where Count == WIDTH-1, so there are exactly WIDTH steps.
- FINISH, normal case:
  - MULT: Hi/Lo load the 64-bit two's-complement product.
  - DIV: quotient and remainder are sign-corrected. The quotient truncates toward zero; the remainder takes the dividend's sign.
  - Done pulses; go to IDLE.
- FINISH, zero divide: Hi/Lo are unchanged; Done and DivZero pulse together.
- 0x80000000 / −1: Lo = 0x80000000, Hi = 0. The result wraps and no exception is raised.
- Hi/Lo hold their value between operations. Only FINISH and Reset change them.
- Start while Busy is ignored. Operands need to be valid only in the accept cycle.

## Timing
- Reset values: Hi = 0, Lo = 0, Busy = 0, Done = 0, DivZero = 0, state IDLE, Count = 0.
- Reset mid-operation aborts the operation and applies the reset values; no Done is produced.
- Start accepted at edge 0:
  - Busy is 1 from edge 0.
  - Iterations run on edges 1..32.
  - FINISH edge is 33: Hi/Lo update, Done = 1 and Busy = 0 during cycle 33→34.
  - Latency: 33 cycles for both MULT and DIV.
- Zero divide accepted at edge 0: FINISH at edge 1, with Done and DivZero high in cycle 1→2.
- Start asserted in the same cycle as Done is accepted, because the state is already IDLE. Back-to-back operations therefore have 34-cycle spacing.
- Busy, Done and DivZero are registered outputs, with no combinational path from the inputs.

## Structure
- Shared package (mdu_pkg) holds:
  - the state enum;
  - the Op encodings OP_MULT = 1'b0 and OP_DIV = 1'b1;
  - the constant ITER = WIDTH.
- Sub-module div_step: combinational, one restoring-division iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: the next partial remainder and quotient.
  - The Booth step stays inline.
- Top level holds the FSM, Count, operand/accumulator registers, sign fix-up and the Hi/Lo registers.

## Test plan
- MULT A = 7, B = −3 (0xFFFFFFFD):
  - Done exactly 33 cycles after the accept edge.
  - Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB.
- MULT A = 0x7FFFFFFF, B = 0x7FFFFFFF, then MULT 0x80000000 × 0x80000000:
  - first result: Hi = 0x3FFFFFFF, Lo = 0x00000001;
  - second result: Hi = 0x40000000, Lo = 0.
- DIV A = −7, B = 2 → Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF.
- DIV A = 100, B = −7 → Lo = 0xFFFFFFF2, Hi = 2.
- DIV A = 0x80000000, B = −1 → Lo = 0x80000000, Hi = 0.
- DIV B = 0 after a prior result of Hi = 5, Lo = 9:
  - DivZero and Done are high in the second cycle after Start;
  - Hi = 5 and Lo = 9 are unchanged.
- Robustness sequence:
  - Start again during iteration 10 → ignored; the original result is unaffected.
  - Reset asserted at iteration 20 → all outputs read 0 the next cycle and no Done appears.
  - A fresh MULT 3 × 4 then gives Lo = 12, Hi = 0.
  - A Start pulsed in its Done cycle is accepted.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared types and constants for the multiply/divide unit.
// Provides the FSM state enum, Op encodings, operand width, iteration count
// and a two's-complement magnitude helper.
package mdu_pkg;
    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;
    localparam int CW    = $clog2(ITER);
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_FINISH} state_t;
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction
endpackage

// File: rtl/mult_div_unit_div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes.
// Ports: i_rem partial remainder, i_quo dividend/quotient shift register,
//        i_div divisor magnitude; o_rem/o_quo next remainder and quotient.
module div_step
    import mdu_pkg::*;
(
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1
    // bits and the trial difference's top bit is a valid borrow flag.
    always_comb begin
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_trial = w_shift - {1'b0, i_div};
        o_rem   = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
        o_quo   = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed MULT/DIV unit owning the HI/LO registers.
// Ports: i_clk, i_reset (sync, active-high), i_start, i_op (0 MULT, 1 DIV),
//        i_a/i_b signed operands; o_hi/o_lo results, o_busy while in flight,
//        o_done one-cycle completion pulse, o_div_zero pulse on DIV by zero.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero
);
    state_t           r_state, w_next;
    logic [CW-1:0]    r_count;
    // MULT: {sign-extended upper half (WIDTH+1), multiplier/low half (WIDTH)}.
    // DIV:  {0, remainder, dividend/quotient}.
    logic [2*WIDTH:0] r_acc;
    logic [WIDTH-1:0] r_opnd, r_hi, r_lo;
    logic             r_booth, r_op, r_qneg, r_rneg, r_dz, r_done, r_dz_out;
    logic [WIDTH:0]   w_up, w_mc, w_sum;
    logic [WIDTH-1:0] w_rem, w_quo;
    logic             w_last;

    div_step u_div_step (
        .i_rem (r_acc[2*WIDTH-1:WIDTH]),
        .i_quo (r_acc[WIDTH-1:0]),
        .i_div (r_opnd),
        .o_rem (w_rem),
        .o_quo (w_quo)
    );

    // Upper half carries one guard bit so subtracting the most negative
    // multiplicand cannot overflow.
    always_comb begin
        w_last = r_count == CW'(ITER - 1);
        w_up   = r_acc[2*WIDTH:WIDTH];
        w_mc   = {r_opnd[WIDTH-1], r_opnd};
        w_sum  = ({r_acc[0], r_booth} == 2'b01) ? w_up + w_mc :
                 ({r_acc[0], r_booth} == 2'b10) ? w_up - w_mc : w_up;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = !i_start ? S_IDLE :
                                (i_op == OP_MULT) ? S_MUL_RUN :
                                (i_b == '0) ? S_FINISH : S_DIV_RUN;
            S_MUL_RUN,
            S_DIV_RUN: w_next = w_last ? S_FINISH : r_state;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_booth  <= 1'b0;
            r_op     <= OP_MULT;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
        end else begin
            r_done   <= r_state == S_FINISH;
            r_dz_out <= r_state == S_FINISH && r_dz;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_count <= '0;
                        r_booth <= 1'b0;
                        r_op    <= i_op;
                        r_dz    <= i_op == OP_DIV && i_b == '0;
                        r_qneg  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                        r_rneg  <= i_a[WIDTH-1];
                        r_opnd  <= (i_op == OP_MULT) ? i_a : mag(i_b);
                        r_acc   <= {(WIDTH+1)'(0), (i_op == OP_MULT) ? i_b : mag(i_a)};
                    end
                end
                S_MUL_RUN: begin
                    r_acc   <= {w_sum[WIDTH], w_sum, r_acc[WIDTH-1:1]};
                    r_booth <= r_acc[0];
                    r_count <= r_count + 1'b1;
                end
                S_DIV_RUN: begin
                    r_acc   <= {1'b0, w_rem, w_quo};
                    r_count <= r_count + 1'b1;
                end
                S_FINISH: begin
                    if (!r_dz) begin
                        r_hi <= (r_op == OP_MULT || !r_rneg) ? r_acc[2*WIDTH-1:WIDTH] : -r_acc[2*WIDTH-1:WIDTH];
                        r_lo <= (r_op == OP_MULT || !r_qneg) ? r_acc[WIDTH-1:0] : -r_acc[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_busy     = r_state != S_IDLE;
    assign o_done     = r_done;
    assign o_div_zero = r_dz_out;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_op       (op),
        .i_a        (a),
        .i_b        (b),
        .o_hi       (hi),
        .o_lo       (lo),
        .o_busy     (busy),
        .o_done     (done),
        .o_div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: signed 64-bit product, or truncating signed division with
    // the remainder taking the dividend's sign; divide by zero keeps HI/LO.
    task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y, output bit dz);
        longint p;
        longint r;
        dz = 1'b0;
        if (o == 1'b0) begin
            p = longint'($signed(x)) * longint'($signed(y));
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (y == 32'd0) begin
            dz = 1'b1;
        end else begin
            p = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
            exp_lo = p[31:0];
            exp_hi = r[31:0];
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the Done cycle so the
    // next call asserts Start inside the Done cycle.
    task automatic do_op(input string tag, input logic o, input logic [31:0] x,
                         input logic [31:0] y, input int glitch_at);
        bit dz;
        int cyc;
        model(o, x, y, dz);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        chk({tag, " busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 40) begin
            if (cyc == glitch_at - 1) begin
                start = 1'b1;
                op = ~o;
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(cyc), dz ? 64'd1 : 64'd33);
        chk({tag, " divzero"}, 64'(div_zero), 64'(dz));
        chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
        chk({tag, " busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
        chk({tag, " dz_pulse"}, 64'(div_zero), 64'd0);
    endtask

    initial begin
        bit          seen;
        logic [31:0] ra, rb;
        logic        ro;
        repeat (2) @(posedge clk);
        #1;
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst dz", 64'(div_zero), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op("mul 7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, -1);
        chk("mul 7x-3 lit hi", 64'(hi), 64'hFFFFFFFF);
        chk("mul 7x-3 lit lo", 64'(lo), 64'hFFFFFFEB);
        pulse_end("mul 7x-3");
        do_op("mul max", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1);
        chk("mul max lit hi", 64'(hi), 64'h3FFFFFFF);
        do_op("mul min", 1'b0, 32'h80000000, 32'h80000000, -1);
        chk("mul min lit hi", 64'(hi), 64'h40000000);
        do_op("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, -1);
        chk("div -7/2 lit lo", 64'(lo), 64'hFFFFFFFD);
        do_op("div 100/-7", 1'b1, 32'd100, 32'hFFFFFFF9, -1);
        chk("div 100/-7 lit lo", 64'(lo), 64'hFFFFFFF2);
        do_op("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, -1);
        chk("div ovf lit lo", 64'(lo), 64'h80000000);
        do_op("div 95/10", 1'b1, 32'd95, 32'd10, -1);
        pulse_end("div 95/10");
        do_op("div zero", 1'b1, 32'd1234, 32'd0, -1);
        chk("div zero lit hi", 64'(hi), 64'd5);
        chk("div zero lit lo", 64'(lo), 64'd9);
        pulse_end("div zero");

        for (int i = 0; i < 12; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'($urandom_range(0, 20)) - 32'd10;
                1: rb = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if (i == 3) ra = 32'h80000000;
            do_op("rand", ro, ra, rb, -1);
        end

        do_op("glitch", 1'b0, 32'hDEADBEEF, 32'h12345678, 10);
        pulse_end("glitch");

        start = 1'b1;
        op = 1'b1;
        a = 32'd1000;
        b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort no_done", 64'(seen), 64'd0);

        do_op("mul 3x4", 1'b0, 32'd3, 32'd4, -1);
        chk("mul 3x4 lit lo", 64'(lo), 64'd12);
        do_op("chained", 1'b1, 32'hFFFFFF00, 32'd3, -1);
        pulse_end("chained");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
